// File: rtl/pipe_pkg.sv
// Constants shared by the pipeline-register stages: bubble instruction,
// control-bundle field offsets, flush counter width and a saturating increment.
package pipe_pkg;

  localparam logic [31:0] PIPE_NOP_INST = 32'h0000_0013;

  localparam int CTRL_MEM_READ  = 0;
  localparam int CTRL_MEM_WRITE = 1;
  localparam int CTRL_MEM_TO_REG = 2;
  localparam int CTRL_REG_WRITE = 3;
  localparam int CTRL_ALU_OP    = 4;
  localparam int CTRL_ALU_SRC   = 6;

  localparam int FLUSH_CNT_W = 16;

  typedef struct packed {
    logic       spare;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       mem_read;
  } ctrl_t;

  function automatic logic [FLUSH_CNT_W-1:0] sat_inc(input logic [FLUSH_CNT_W-1:0] v);
    return (v == {FLUSH_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage slot (valid bit + payload); flush beats load beats unload.
// Payload only changes on a load, so a stalled entry stays stable.
module pipe_slot #(
  parameter int                  CTRL_W   = 8,
  parameter int                  PAY_W    = 128,
  parameter int                  INST_W   = 32,
  parameter logic [INST_W-1:0]   RST_INST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              load,
  input  logic              unload,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic [PAY_W-1:0]  data_d,
  input  logic [INST_W-1:0] inst_d,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl_q,
  output logic [PAY_W-1:0]  data_q,
  output logic [INST_W-1:0] inst_q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid  <= 1'b0;
      ctrl_q <= '0;
      data_q <= '0;
      inst_q <= RST_INST;
    end else begin
      if (flush)       valid <= 1'b0;
      else if (load)   valid <= 1'b1;
      else if (unload) valid <= 1'b0;

      if (load && !flush) begin
        ctrl_q <= ctrl_d;
        data_q <= data_d;
        inst_q <= inst_d;
      end
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register, 1-cycle latency; SKID=1 adds a skid slot so
// in_ready_o is a flop, SKID=0 stalls combinationally on out_ready_i.
module pipe_stage_reg import pipe_pkg::*; #(
  parameter int                CTRL_W   = 8,
  parameter int                DATA_W   = 32,
  parameter int                NUM_DATA = 4,
  parameter int                INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(PIPE_NOP_INST),
  parameter bit                SKID     = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [CTRL_W-1:0]          ctrl_i,
  input  logic [NUM_DATA*DATA_W-1:0] data_i,
  input  logic [INST_W-1:0]          inst_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [CTRL_W-1:0]          ctrl_o,
  output logic [NUM_DATA*DATA_W-1:0] data_o,
  output logic [INST_W-1:0]          inst_o,
  output logic [FLUSH_CNT_W-1:0]     flush_cnt_o
);

  localparam int PAY_W = NUM_DATA * DATA_W;

  logic              main_v, skid_v, accept, drain, main_load;
  logic [CTRL_W-1:0] main_ctrl, ld_ctrl;
  logic [PAY_W-1:0]  main_data, ld_data;
  logic [INST_W-1:0] main_inst, ld_inst;
  logic [FLUSH_CNT_W-1:0] flush_cnt;

  assign accept = in_valid_i && in_ready_o;
  assign drain  = main_v && out_ready_i;

  generate
    if (SKID) begin : g_skid
      logic [CTRL_W-1:0] skid_ctrl;
      logic [PAY_W-1:0]  skid_data;
      logic [INST_W-1:0] skid_inst;

      // Skid is only ever valid while main is valid, so it refills main on drain.
      assign in_ready_o = !skid_v;
      assign main_load  = (!main_v || drain) && (skid_v || accept);
      assign ld_ctrl    = skid_v ? skid_ctrl : ctrl_i;
      assign ld_data    = skid_v ? skid_data : data_i;
      assign ld_inst    = skid_v ? skid_inst : inst_i;

      pipe_slot #(.CTRL_W(CTRL_W), .PAY_W(PAY_W), .INST_W(INST_W), .RST_INST(NOP_INST)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush_i),
        .load   (accept && main_v && !drain),
        .unload (drain),
        .ctrl_d (ctrl_i),
        .data_d (data_i),
        .inst_d (inst_i),
        .valid  (skid_v),
        .ctrl_q (skid_ctrl),
        .data_q (skid_data),
        .inst_q (skid_inst)
      );
    end else begin : g_noskid
      assign in_ready_o = !main_v || out_ready_i;
      assign main_load  = accept;
      assign ld_ctrl    = ctrl_i;
      assign ld_data    = data_i;
      assign ld_inst    = inst_i;
      assign skid_v     = 1'b0;
    end
  endgenerate

  pipe_slot #(.CTRL_W(CTRL_W), .PAY_W(PAY_W), .INST_W(INST_W), .RST_INST(NOP_INST)) u_main (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush_i),
    .load   (main_load),
    .unload (drain),
    .ctrl_d (ld_ctrl),
    .data_d (ld_data),
    .inst_d (ld_inst),
    .valid  (main_v),
    .ctrl_q (main_ctrl),
    .data_q (main_data),
    .inst_q (main_inst)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              flush_cnt <= '0;
    else if (flush_i && (main_v || skid_v)) flush_cnt <= sat_inc(flush_cnt);
  end

  assign out_valid_o = main_v;
  assign ctrl_o      = main_v ? main_ctrl : '0;
  assign data_o      = main_v ? main_data : '0;
  assign inst_o      = main_v ? main_inst : NOP_INST;
  assign flush_cnt_o = flush_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=1 and SKID=0 instances share stimulus and are
// compared every cycle against a bounded-queue model of the stage.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  logic         clk = 1'b0;
  logic         rst, flush, iv, ordy;
  logic [7:0]   ctrl_in;
  logic [127:0] data_in;
  logic [31:0]  inst_in;

  logic         ir1, ov1, ir0, ov0;
  logic [7:0]   c1, c0;
  logic [127:0] d1, d0;
  logic [31:0]  i1, i0;
  logic [15:0]  cnt1, cnt0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.SKID(1'b1)) dut1 (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(iv), .in_ready_o(ir1),
    .ctrl_i(ctrl_in), .data_i(data_in), .inst_i(inst_in), .out_valid_o(ov1),
    .out_ready_i(ordy), .ctrl_o(c1), .data_o(d1), .inst_o(i1), .flush_cnt_o(cnt1));

  pipe_stage_reg #(.SKID(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(iv), .in_ready_o(ir0),
    .ctrl_i(ctrl_in), .data_i(data_in), .inst_i(inst_in), .out_valid_o(ov0),
    .out_ready_i(ordy), .ctrl_o(c0), .data_o(d0), .inst_o(i0), .flush_cnt_o(cnt0));

  typedef struct packed {
    logic [7:0]   c;
    logic [127:0] d;
    logic [31:0]  i;
  } ent_t;

  typedef struct {
    bit          iv, ordy, fl, ov, ir;
    logic [15:0] cnt;
  } vec_t;

  localparam ent_t BUBBLE = '{c: 8'h0, d: 128'h0, i: 32'h0000_0013};

  ent_t        q1[$], q0[$];
  logic [15:0] mcnt1, mcnt0;
  int          errors = 0, checks = 0;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic drive(input bit v, input bit r, input bit f);
    @(negedge clk);
    iv = v; ordy = r; flush = f;
    ctrl_in = 8'($urandom);
    ctrl_in[CTRL_MEM_WRITE]  = ctrl_in[CTRL_MEM_WRITE] & ~ctrl_in[CTRL_MEM_READ];
    ctrl_in[CTRL_MEM_TO_REG] = ctrl_in[CTRL_MEM_READ] & ctrl_in[CTRL_REG_WRITE];
    if (ctrl_in[CTRL_ALU_SRC]) ctrl_in[CTRL_ALU_OP +: 2] = 2'b00;
    data_in = {$urandom, $urandom, $urandom, $urandom};
    inst_in = $urandom;
    #1;
  endtask

  task automatic cmp_model();
    ent_t e1, e0;
    e1 = (q1.size() > 0) ? q1[0] : BUBBLE;
    e0 = (q0.size() > 0) ? q0[0] : BUBBLE;
    chk("s1_vld",  256'(ov1),  256'(q1.size() > 0));
    chk("s1_rdy",  256'(ir1),  256'(q1.size() < 2));
    chk("s1_ctrl", 256'(c1),   256'(e1.c));
    chk("s1_data", 256'(d1),   256'(e1.d));
    chk("s1_inst", 256'(i1),   256'(e1.i));
    chk("s1_fcnt", 256'(cnt1), 256'(mcnt1));
    chk("s0_vld",  256'(ov0),  256'(q0.size() > 0));
    chk("s0_rdy",  256'(ir0),  256'((q0.size() == 0) || ordy));
    chk("s0_ctrl", 256'(c0),   256'(e0.c));
    chk("s0_data", 256'(d0),   256'(e0.d));
    chk("s0_inst", 256'(i0),   256'(e0.i));
    chk("s0_fcnt", 256'(cnt0), 256'(mcnt0));
  endtask

  // Stage modelled as a FIFO of depth 2 (skid) or 1 (no skid); flush empties it.
  task automatic advance();
    bit   r1, r0;
    ent_t e;
    r1 = q1.size() < 2;
    r0 = (q0.size() == 0) || ordy;
    e  = '{c: ctrl_in, d: data_in, i: inst_in};
    @(posedge clk);
    if (flush) begin
      if (q1.size() > 0 && mcnt1 != 16'hFFFF) mcnt1 = mcnt1 + 16'd1;
      if (q0.size() > 0 && mcnt0 != 16'hFFFF) mcnt0 = mcnt0 + 16'd1;
      q1.delete();
      q0.delete();
    end else begin
      if (q1.size() > 0 && ordy) void'(q1.pop_front());
      if (q0.size() > 0 && ordy) void'(q0.pop_front());
      if (iv && r1) q1.push_back(e);
      if (iv && r0) q0.push_back(e);
    end
  endtask

  task automatic step(input bit v, input bit r, input bit f);
    drive(v, r, f);
    cmp_model();
    advance();
  endtask

  vec_t        tbl[15];
  logic [31:0] sent[8];
  logic [31:0] held1, held0;

  initial begin
    rst = 1'b1; flush = 1'b0; iv = 1'b0; ordy = 1'b0;
    ctrl_in = '0; data_in = '0; inst_in = '0;
    mcnt1 = '0; mcnt0 = '0;

    // Directed SKID=1 sequence, expectations worked out by hand from an empty stage.
    tbl[0]  = '{0, 1, 0, 0, 1, 16'd0};
    tbl[1]  = '{0, 1, 1, 0, 1, 16'd0};
    tbl[2]  = '{1, 1, 0, 0, 1, 16'd0};
    tbl[3]  = '{1, 1, 0, 1, 1, 16'd0};
    tbl[4]  = '{1, 0, 0, 1, 1, 16'd0};
    tbl[5]  = '{1, 0, 0, 1, 0, 16'd0};
    tbl[6]  = '{1, 0, 0, 1, 0, 16'd0};
    tbl[7]  = '{0, 1, 0, 1, 0, 16'd0};
    tbl[8]  = '{0, 1, 0, 1, 1, 16'd0};
    tbl[9]  = '{1, 0, 0, 0, 1, 16'd0};
    tbl[10] = '{1, 0, 0, 1, 1, 16'd0};
    tbl[11] = '{1, 0, 1, 1, 0, 16'd0};
    tbl[12] = '{0, 1, 0, 0, 1, 16'd1};
    tbl[13] = '{1, 1, 1, 0, 1, 16'd1};
    tbl[14] = '{0, 1, 0, 0, 1, 16'd1};

    #1;
    chk("rst_vld",  256'(ov1),  256'(0));
    chk("rst_rdy",  256'(ir1),  256'(1));
    chk("rst_inst", 256'(i1),   256'(32'h13));
    chk("rst_ctrl", 256'(c1),   256'(0));
    chk("rst_data", 256'(d1),   256'(0));
    chk("rst_fcnt", 256'(cnt1), 256'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);

    for (int k = 0; k < 15; k++) begin
      drive(tbl[k].iv, tbl[k].ordy, tbl[k].fl);
      chk($sformatf("tbl%0d_vld", k),  256'(ov1),  256'(tbl[k].ov));
      chk($sformatf("tbl%0d_rdy", k),  256'(ir1),  256'(tbl[k].ir));
      chk($sformatf("tbl%0d_fcnt", k), 256'(cnt1), 256'(tbl[k].cnt));
      cmp_model();
      advance();
    end

    // Reset asserted between edges with entries held.
    step(1, 0, 0);
    step(1, 0, 0);
    #2;
    iv = 1'b0; flush = 1'b0; rst = 1'b1;
    #1;
    chk("mrst_vld",  256'(ov1),  256'(0));
    chk("mrst_rdy",  256'(ir1),  256'(1));
    chk("mrst_inst", 256'(i1),   256'(32'h13));
    chk("mrst_ctrl", 256'(c1),   256'(0));
    chk("mrst_data", 256'(d1),   256'(0));
    chk("mrst_fcnt", 256'(cnt1), 256'(0));
    chk("mrst_vld0", 256'(ov0),  256'(0));
    q1.delete(); q0.delete();
    mcnt1 = '0; mcnt0 = '0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk);

    // Streaming: 8 back-to-back entries, each visible the cycle after it is sent.
    for (int k = 0; k < 9; k++) begin
      drive(k < 8, 1, 0);
      if (k == 0) chk("strm_first_vld", 256'(ov1), 256'(0));
      else begin
        chk($sformatf("strm%0d_vld", k),  256'(ov1), 256'(1));
        chk($sformatf("strm%0d_inst", k), 256'(i1),  256'(sent[k-1]));
      end
      if (k < 8) sent[k] = inst_in;
      cmp_model();
      advance();
    end
    step(0, 1, 0);

    // Back-pressure: skid fills, SKID=0 stalls in the same cycle, outputs hold.
    step(1, 0, 0);
    drive(1, 0, 0);
    chk("bp_s0_rdy", 256'(ir0), 256'(0));
    chk("bp_s0_vld", 256'(ov0), 256'(1));
    held1 = i1; held0 = i0;
    cmp_model();
    advance();
    for (int k = 0; k < 2; k++) begin
      drive(1, 0, 0);
      chk("bp_s1_rdy",   256'(ir1), 256'(0));
      chk("bp_s1_hold",  256'(i1),  256'(held1));
      chk("bp_s0_hold",  256'(i0),  256'(held0));
      cmp_model();
      advance();
    end
    step(0, 1, 0);
    step(0, 1, 0);

    // Flush with both slots full.
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 1);
    drive(0, 1, 0);
    chk("fl_vld",  256'(ov1),  256'(0));
    chk("fl_inst", 256'(i1),   256'(32'h13));
    chk("fl_fcnt", 256'(cnt1), 256'(1));
    cmp_model();
    advance();

    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    step(0, 1, 0);
    step(0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter CTRL_W, default 8, control-bundle width.
REQ-002 SHALL have parameter DATA_W, default 32, width of one datapath word.
REQ-003 SHALL have parameter NUM_DATA, default 4, number of datapath words (pc+4, rs1, rs2, imm).
REQ-004 SHALL have parameter INST_W, default 32, instruction width.
REQ-005 SHALL have parameter NOP_INST, default 32'h00000013, bubble instruction pattern.
REQ-006 SHALL have parameter SKID, default 1: 1 = two-entry skid buffer; 0 = single register with stall.
REQ-007 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-008 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port flush_i, input, 1, synchronous kill of all held entries.
REQ-010 SHALL have port in_valid_i, input, 1, upstream entry valid.
REQ-011 SHALL have port in_ready_o, output, 1, stage can accept an entry.
REQ-012 SHALL have port ctrl_i, input, CTRL_W, control bundle (memRead, memWrite, memtoReg, regWrite, ALUop, ALUsrc).
REQ-013 SHALL have port data_i, input, NUM_DATA*DATA_W, packed datapath words.
REQ-014 SHALL have port inst_i, input, INST_W, instruction.
REQ-015 SHALL have port out_valid_o, output, 1, downstream entry valid.
REQ-016 SHALL have port out_ready_i, input, 1, downstream accepts.
REQ-017 SHALL have ports ctrl_o, data_o and inst_o, outputs, widths as inputs, held entry.
REQ-018 SHALL have port flush_cnt_o, output, 16, saturating count of flushes that killed at least one valid entry.

Function
REQ-019 SHALL accept an entry when in_valid_i && in_ready_o and deliver one when out_valid_o && out_ready_i.
REQ-020 SHALL have 1-cycle latency from accept to out_valid_o and sustain 1 entry/cycle with out_ready_i held high.
REQ-021 SHALL, with SKID=1, drive in_ready_o = !skid_valid as a registered signal with no combinational path from out_ready_i.
REQ-022 SHALL, with SKID=1, load main from skid if skid is valid, otherwise from the input, whenever main is empty or draining.
REQ-023 SHALL, with SKID=1, capture an accepted input into skid when main is full and not draining.
REQ-024 SHALL, with SKID=0, drive in_ready_o = !out_valid_o || out_ready_i.
REQ-025 SHALL hold ctrl_o, data_o and inst_o stable while out_valid_o=1 and out_ready_i=0.
REQ-026 SHALL, when out_valid_o=0, present a bubble: ctrl_o=0, data_o=0, inst_o=NOP_INST.
REQ-027 SHALL, on flush_i=1, clear the main and skid valid bits at the next edge; an input handshaking that cycle is dropped; out_valid_o=0 the following cycle.
REQ-028 SHALL give flush_i priority when flush_i and a handshake coincide; no entry survives.
REQ-029 SHALL increment flush_cnt_o on flush_i when any entry is valid, saturating at 16'hFFFF without wrap.
REQ-030 SHALL preserve entry order; no duplication or loss except by flush.

Reset
REQ-031 SHALL, on rst, asynchronously set valid bits to 0, flush_cnt_o to 0, ctrl_o/data_o to 0 and inst_o to NOP_INST.
REQ-032 SHALL, on rst, drive in_ready_o to 1 (SKID=1) from reset assertion onward.
REQ-033 SHALL discard entries in flight when rst asserts mid-transfer and resume as empty on the first edge after release.

Structure
REQ-034 SHALL take NOP_INST and the control-bundle field offsets from the shared package pipe_pkg, alongside other pipeline-register constants.
REQ-035 SHALL implement each storage slot (valid + payload) as sub-module pipe_slot, instantiated twice when SKID=1.

Verification
REQ-036 SHALL cover streaming: 8 back-to-back entries, out_ready_i=1 -> outputs in order, 1-cycle latency, no bubbles.
REQ-037 SHALL cover back-pressure: out_ready_i=0 for 3 cycles with in_valid_i=1 -> skid fills, in_ready_o=0 next cycle, outputs stable, no loss after release.
REQ-038 SHALL cover flush with both slots full: flush_i=1 -> out_valid_o=0, inst_o=32'h00000013, flush_cnt_o=1.
REQ-039 SHALL cover flush on an empty stage: flush_i=1 -> flush_cnt_o unchanged.
REQ-040 SHALL cover reset: rst asserted mid-stream between edges -> outputs at reset values immediately, in_ready_o=1.
REQ-041 SHALL cover SKID=0 stall: out_ready_i=0 with out_valid_o=1 -> in_ready_o=0 in the same cycle, entry held.
